// File: rtl/proc_mem_responder_if.sv
// Processor-side bus for proc_mem_responder: instruction fetch, data memory,
// program loader and MMIO signals grouped as one interface.
interface proc_mem_responder_if;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;

    logic        dmemreq_val;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic [31:0] dmemresp_rdata;

    logic        ld_val;
    logic        ld_rdy;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        proc_rst;

    logic [31:0] mmio_out;
    logic        mmio_out_val;
    logic [31:0] mmio_in;
    logic        err;

    modport master (
        output imemreq_val, imemreq_addr,
        output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
        output ld_val, ld_addr, ld_data, ld_done, mmio_in,
        input  imemresp_data, dmemresp_rdata, ld_rdy, proc_rst,
        input  mmio_out, mmio_out_val, err
    );

    modport slave (
        input  imemreq_val, imemreq_addr,
        input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
        input  ld_val, ld_addr, ld_data, ld_done, mmio_in,
        output imemresp_data, dmemresp_rdata, ld_rdy, proc_rst,
        output mmio_out, mmio_out_val, err
    );
endinterface

// File: rtl/proc_mem_responder.sv
// Memory-side responder for the TinyRV1 pipeline: shared word array, two MMIO
// words, and a loader front end that holds the processor in reset until done.
module proc_mem_responder #(
    parameter int unsigned WORDS         = 256,
    parameter logic [31:0] MMIO_OUT_ADDR = 32'h0000_2000,
    parameter logic [31:0] MMIO_IN_ADDR  = 32'h0000_2004
) (
    input  logic                 clk,
    input  logic                 rst,
    proc_mem_responder_if.slave  bus
);
    localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [29:0] WORDS_W = 30'(WORDS);

    typedef enum logic {LOAD, RUN} state_e;

    state_e      state_q, state_d;
    logic [31:0] mmio_out_q, mmio_out_d;
    logic        mmio_out_val_q, mmio_out_val_d;
    logic        err_q, err_d;

    logic [31:0] mem [WORDS];
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [31:0]      mem_wdata;

    logic [IDX_W-1:0] i_idx, d_idx, l_idx;
    logic             d_is_out, d_is_in, d_is_arr;

    // Full-width index compare, so addresses past the array never alias back into it.
    function automatic logic in_array(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:2] < WORDS_W);
    endfunction

    assign i_idx    = bus.imemreq_addr[IDX_W+1:2];
    assign d_idx    = bus.dmemreq_addr[IDX_W+1:2];
    assign l_idx    = bus.ld_addr[IDX_W+1:2];
    assign d_is_out = (bus.dmemreq_addr == MMIO_OUT_ADDR);
    assign d_is_in  = (bus.dmemreq_addr == MMIO_IN_ADDR);
    assign d_is_arr = in_array(bus.dmemreq_addr) && !d_is_out && !d_is_in;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d            = state_q;
        mmio_out_d         = mmio_out_q;
        mmio_out_val_d     = 1'b0;
        err_d              = err_q;
        mem_we             = 1'b0;
        mem_waddr          = d_idx;
        mem_wdata          = bus.dmemreq_wdata;
        bus.imemresp_data  = '0;
        bus.dmemresp_rdata = '0;

        unique case (state_q)
            LOAD: begin
                if (bus.ld_val) begin
                    if (in_array(bus.ld_addr)) begin
                        mem_we    = 1'b1;
                        mem_waddr = l_idx;
                        mem_wdata = bus.ld_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (bus.ld_done) state_d = RUN;
            end
            RUN: begin
                if (bus.imemreq_val) begin
                    if (in_array(bus.imemreq_addr) &&
                        bus.imemreq_addr != MMIO_OUT_ADDR &&
                        bus.imemreq_addr != MMIO_IN_ADDR)
                        bus.imemresp_data = mem[i_idx];
                    else
                        err_d = 1'b1;
                end
                if (bus.dmemreq_val && !bus.dmemreq_type) begin
                    if (d_is_out)      bus.dmemresp_rdata = mmio_out_q;
                    else if (d_is_in)  bus.dmemresp_rdata = bus.mmio_in;
                    else if (d_is_arr) bus.dmemresp_rdata = mem[d_idx];
                    else               err_d = 1'b1;
                end
                if (bus.dmemreq_val && bus.dmemreq_type) begin
                    if (d_is_out) begin
                        mmio_out_d     = bus.dmemreq_wdata;
                        mmio_out_val_d = 1'b1;
                    end else if (d_is_arr) begin
                        mem_we = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= LOAD;
            mmio_out_q     <= '0;
            mmio_out_val_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            mmio_out_q     <= mmio_out_d;
            mmio_out_val_q <= mmio_out_val_d;
            err_q          <= err_d;
        end
    end

    // NOTE: the array has no reset so a program survives a processor reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.proc_rst     = (state_q == LOAD);
    assign bus.ld_rdy       = (state_q == LOAD);
    assign bus.mmio_out     = mmio_out_q;
    assign bus.mmio_out_val = mmio_out_val_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_proc_mem_responder.sv
// Self-checking bench for proc_mem_responder: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_proc_mem_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    proc_mem_responder_if bus ();

    proc_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [31:0] m_mem [256];
    bit        m_run;
    bit [31:0] m_mmio;
    bit        m_mval;
    bit        m_err;

    function automatic bit good_word(input logic [31:0] a);
        return (a % 4 == 0) && ((a >> 2) < 256);
    endfunction

    function automatic logic [31:0] exp_imem();
        if (!m_run || !bus.imemreq_val) return 32'h0;
        if (good_word(bus.imemreq_addr)) return m_mem[int'(bus.imemreq_addr >> 2)];
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_dmem();
        if (!m_run || !bus.dmemreq_val || bus.dmemreq_type) return 32'h0;
        if (bus.dmemreq_addr == 32'h2000) return m_mmio;
        if (bus.dmemreq_addr == 32'h2004) return bus.mmio_in;
        if (good_word(bus.dmemreq_addr)) return m_mem[int'(bus.dmemreq_addr >> 2)];
        return 32'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_mmio <= 32'h0;
            m_mval <= 1'b0;
            m_err  <= 1'b0;
        end else if (!m_run) begin
            m_mval <= 1'b0;
            if (bus.ld_val) begin
                if (good_word(bus.ld_addr)) m_mem[int'(bus.ld_addr >> 2)] <= bus.ld_data;
                else m_err <= 1'b1;
            end
            if (bus.ld_done) m_run <= 1'b1;
        end else begin
            m_mval <= 1'b0;
            if (bus.imemreq_val && !good_word(bus.imemreq_addr)) m_err <= 1'b1;
            if (bus.dmemreq_val) begin
                if (bus.dmemreq_type) begin
                    if (bus.dmemreq_addr == 32'h2000) begin
                        m_mmio <= bus.dmemreq_wdata;
                        m_mval <= 1'b1;
                    end else if (bus.dmemreq_addr != 32'h2004 && good_word(bus.dmemreq_addr))
                        m_mem[int'(bus.dmemreq_addr >> 2)] <= bus.dmemreq_wdata;
                    else
                        m_err <= 1'b1;
                end else if (bus.dmemreq_addr != 32'h2000 && bus.dmemreq_addr != 32'h2004 &&
                             !good_word(bus.dmemreq_addr))
                    m_err <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One compare process: outputs are meaningful on every cycle.
    always @(negedge clk) begin
        check("imemresp_data",  bus.imemresp_data,  exp_imem());
        check("dmemresp_rdata", bus.dmemresp_rdata, exp_dmem());
        check("proc_rst",       32'(bus.proc_rst),     32'(!m_run));
        check("ld_rdy",         32'(bus.ld_rdy),       32'(!m_run));
        check("mmio_out",       bus.mmio_out,          m_mmio);
        check("mmio_out_val",   32'(bus.mmio_out_val), 32'(m_mval));
        check("err",            32'(bus.err),          32'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.imemreq_val   = 1'b0;
        bus.imemreq_addr  = 32'h0;
        bus.dmemreq_val   = 1'b0;
        bus.dmemreq_type  = 1'b0;
        bus.dmemreq_addr  = 32'h0;
        bus.dmemreq_wdata = 32'h0;
        bus.ld_val        = 1'b0;
        bus.ld_addr       = 32'h0;
        bus.ld_data       = 32'h0;
        bus.ld_done       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        idle();
        bus.ld_val  = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        tick();
        idle();
    endtask

    task automatic release_proc();
        idle();
        bus.ld_done = 1'b1;
        tick();
        idle();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        idle();
        bus.dmemreq_val   = 1'b1;
        bus.dmemreq_type  = 1'b1;
        bus.dmemreq_addr  = a;
        bus.dmemreq_wdata = d;
        tick();
        idle();
    endtask

    task automatic set_load(input logic [31:0] a);
        idle();
        bus.dmemreq_val  = 1'b1;
        bus.dmemreq_addr = a;
        #1;
    endtask

    task automatic set_fetch(input logic [31:0] a);
        idle();
        bus.imemreq_val  = 1'b1;
        bus.imemreq_addr = a;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h2000;
            1:       return 32'h2004;
            2:       return ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
            3:       return 32'h400 + ($urandom_range(0, 255) << 2);
            4:       return $urandom;
            default: return $urandom_range(0, 255) << 2;
        endcase
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        bus.mmio_in = 32'h0;
        do_reset();
        check("reset proc_rst", 32'(bus.proc_rst), 32'h1);
        check("reset ld_rdy",   32'(bus.ld_rdy),   32'h1);
        check("reset mmio_out", bus.mmio_out,      32'h0);
        check("reset err",      32'(bus.err),      32'h0);

        for (int i = 0; i < 256; i++) load_word(i << 2, (i == 'h11) ? 32'h0 : $urandom);
        load_word(32'h0, 32'h0000_0013);
        load_word(32'h4, 32'h00A0_0093);
        idle();
        bus.ld_done = 1'b1;
        #1;
        check("proc_rst before edge", 32'(bus.proc_rst), 32'h1);
        tick();
        idle();
        check("proc_rst after done", 32'(bus.proc_rst), 32'h0);
        check("ld_rdy after done",   32'(bus.ld_rdy),   32'h0);
        set_fetch(32'h4);
        check("fetch 0x4", bus.imemresp_data, 32'h00A0_0093);

        store(32'h40, 32'hDEAD_BEEF);
        set_load(32'h40);
        check("load 0x40", bus.dmemresp_rdata, 32'hDEAD_BEEF);
        idle();
        bus.dmemreq_val   = 1'b1;
        bus.dmemreq_type  = 1'b1;
        bus.dmemreq_addr  = 32'h44;
        bus.dmemreq_wdata = 32'hCAFE_F00D;
        bus.imemreq_val   = 1'b1;
        bus.imemreq_addr  = 32'h44;
        #1;
        check("fetch during store old", bus.imemresp_data, 32'h0);
        tick();
        set_load(32'h44);
        check("load 0x44 new", bus.dmemresp_rdata, 32'hCAFE_F00D);

        store(32'h2000, 32'h2A);
        check("mmio_out value", bus.mmio_out,            32'h2A);
        check("mmio_out_val 1", 32'(bus.mmio_out_val),  32'h1);
        tick();
        check("mmio_out_val 0", 32'(bus.mmio_out_val),  32'h0);
        bus.mmio_in = 32'h55;
        set_load(32'h2004);
        check("load mmio_in", bus.dmemresp_rdata, 32'h55);
        set_load(32'h2000);
        check("load mmio_out", bus.dmemresp_rdata, 32'h2A);

        check("err before errors", 32'(bus.err), 32'h0);
        set_load(32'h41);
        check("misaligned load 0", bus.dmemresp_rdata, 32'h0);
        tick();
        check("err after misaligned", 32'(bus.err), 32'h1);
        store(32'h400, 32'h1111_1111);
        store(32'h2004, 32'h2222_2222);
        set_fetch(32'h2000);
        check("fetch mmio 0", bus.imemresp_data, 32'h0);
        set_load(32'h0);
        check("word 0 not aliased", bus.dmemresp_rdata, 32'h0000_0013);
        tick();
        check("err sticky", 32'(bus.err), 32'h1);

        store(32'h8, 32'h1234);
        rst = 1'b1;
        #1;
        check("mid-run rst proc_rst", 32'(bus.proc_rst), 32'h1);
        check("mid-run rst mmio_out", bus.mmio_out,      32'h0);
        check("mid-run rst err",      32'(bus.err),      32'h0);
        tick();
        rst = 1'b0;
        release_proc();
        set_fetch(32'h8);
        check("fetch 0x8 kept", bus.imemresp_data, 32'h1234);

        do_reset();
        idle();
        bus.ld_val  = 1'b1;
        bus.ld_addr = 32'h10;
        bus.ld_data = 32'h77;
        bus.ld_done = 1'b1;
        tick();
        idle();
        check("run after ld+done", 32'(bus.proc_rst), 32'h0);
        load_word(32'h10, 32'h99);
        set_fetch(32'h10);
        check("fetch 0x10", bus.imemresp_data, 32'h77);

        do_reset();
        load_word(32'h401, 32'h5555_5555);
        load_word(32'h400, 32'h6666_6666);
        check("loader err", 32'(bus.err), 32'h1);
        release_proc();
        set_load(32'h0);
        check("loader err no write", bus.dmemresp_rdata, 32'h0000_0013);

        for (int i = 0; i < 2000; i++) begin
            if (i % 500 == 250) begin
                do_reset();
                for (int k = 0; k < 8; k++)
                    load_word(($urandom_range(0, 15) == 0) ? rand_addr() : ($urandom_range(0, 255) << 2),
                              $urandom);
                release_proc();
            end
            bus.imemreq_val   = 1'($urandom_range(0, 1));
            bus.imemreq_addr  = rand_addr();
            bus.dmemreq_val   = 1'($urandom_range(0, 3) != 0);
            bus.dmemreq_type  = 1'($urandom_range(0, 1));
            bus.dmemreq_addr  = rand_addr();
            bus.dmemreq_wdata = $urandom;
            bus.ld_val        = 1'($urandom_range(0, 1));
            bus.ld_addr       = $urandom_range(0, 255) << 2;
            bus.ld_data       = $urandom;
            bus.ld_done       = 1'($urandom_range(0, 1));
            bus.mmio_in       = $urandom;
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
